// File: rtl/link_frame_sequencer_pkg.sv
// Shared types and constants for the link frame sequencer.
// Frame geometry: 4 x Hamming(7,4) = 28 bits, sent as 14 QPSK symbols.
package link_seq_pkg;

    localparam int WORD_W     = 16;
    localparam int SYM_BITS   = 2;
    localparam int FRAME_BITS = 28;
    localparam int CHAN_LAT   = 3;
    localparam int TIMEOUT    = 64;
    localparam int NSYM       = FRAME_BITS / SYM_BITS;
    localparam int CNT_W      = $clog2(NSYM + CHAN_LAT + 1);

    // XFER counter landmarks, sized to the counter so compares stay width-clean
    localparam logic [CNT_W-1:0] NSYM_C    = CNT_W'(NSYM);
    localparam logic [CNT_W-1:0] CAP_FIRST = CNT_W'(CHAN_LAT);
    localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'(NSYM - 1 + CHAN_LAT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENC   = 3'd1,
        XFER  = 3'd2,
        DEINT = 3'd3,
        OUT   = 3'd4
    } state_t;

    // Number of set bits in a data word (used by the bit-error counter)
    function automatic logic [4:0] popcount16(input logic [WORD_W-1:0] v);
        logic [4:0] acc;
        acc = '0;
        for (int i = 0; i < WORD_W; i++) begin
            acc = acc + 5'(v[i]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/link_frame_sequencer_wdog.sv
// link_wdog: loadable down-counter watchdog. Reloads to TIMEOUT-1 while
// clear is high; while enabled it counts down and flags expire during the
// TIMEOUT-th enabled cycle, so the owner can bail out at that edge.
module link_wdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload on clear, otherwise count down to zero and hold
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = LOAD;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign expire = enable && !clear && (cnt_q == '0);

    // Counter register, armed at reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/link_frame_sequencer.sv
// link_frame_sequencer: frame-level controller for the baseband loopback
// chain. Accepts a source word, runs the interleaver, streams the frame out
// as symbols, reassembles the returning symbols after the channel latency,
// runs the deinterleaver and hands the decoded word to the consumer.
// Optional feature macro: BER_CNT_EN (adds the bit_err_cnt output).
module link_frame_sequencer
    import link_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [WORD_W-1:0]     src_data,
    output logic [WORD_W-1:0]     src_word,
    output logic                  inter_en,
    input  logic                  inter_eno,
    input  logic [FRAME_BITS-1:0] inter_data,
    output logic [SYM_BITS-1:0]   sym_out,
    input  logic [SYM_BITS-1:0]   sym_in,
    output logic                  deinter_en,
    output logic [FRAME_BITS-1:0] deinter_data,
    input  logic                  deinter_eno,
    input  logic [WORD_W-1:0]     dec_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_W-1:0]     out_data,
    output logic                  busy,
    output logic                  err,
`ifdef BER_CNT_EN
    output logic [31:0]           bit_err_cnt,
`endif
    output logic [15:0]           frame_cnt
);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      cap_idx;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [FRAME_BITS-1:0] deinter_data_q, deinter_data_d;
    logic [WORD_W-1:0]     src_word_q, src_word_d;
    logic [WORD_W-1:0]     out_data_q, out_data_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  src_ready_q, src_ready_d;
    logic                  inter_en_q, inter_en_d;
    logic                  deinter_en_q, deinter_en_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic                  wdog_run;
    logic                  wdog_expire;
`ifdef BER_CNT_EN
    logic [31:0]           bit_err_cnt_q, bit_err_cnt_d;
    logic [32:0]           ber_sum;
`endif

    // One watchdog covers both handshake waits; it is re-armed in every
    // other state so each wait starts with a full budget.
    assign wdog_run = (state_q == ENC) || (state_q == DEINT);

    link_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (!wdog_run),
        .enable (wdog_run),
        .expire (wdog_expire)
    );

    assign cap_idx = cnt_q - CAP_FIRST;

`ifdef BER_CNT_EN
    assign ber_sum = {1'b0, bit_err_cnt_q} + 33'(popcount16(src_word_q ^ out_data_q));
`endif

    // Symbol to the modulator: current frame slice while streaming, else idle 0
    always_comb begin
        sym_out = '0;
        if ((state_q == XFER) && (cnt_q < NSYM_C)) begin
            sym_out = frame_q[int'(cnt_q) * SYM_BITS +: SYM_BITS];
        end
    end

    // Next-state and next-output computation for the frame sequence
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        frame_d        = frame_q;
        deinter_data_d = deinter_data_q;
        src_word_d     = src_word_q;
        out_data_d     = out_data_q;
        frame_cnt_d    = frame_cnt_q;
        src_ready_d    = src_ready_q;
        inter_en_d     = inter_en_q;
        deinter_en_d   = deinter_en_q;
        out_valid_d    = out_valid_q;
        busy_d         = busy_q;
        err_d          = 1'b0;
`ifdef BER_CNT_EN
        bit_err_cnt_d  = bit_err_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                src_ready_d = 1'b1;
                if (src_valid && src_ready_q) begin
                    src_word_d  = src_data;
                    src_ready_d = 1'b0;
                    inter_en_d  = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ENC;
                end
            end
            ENC: begin
                if (inter_eno) begin
                    frame_d    = inter_data;
                    inter_en_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = XFER;
                end else if (wdog_expire) begin
                    err_d       = 1'b1;
                    inter_en_d  = 1'b0;
                    src_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            XFER: begin
                // Symbol k left CHAN_LAT cycles ago is arriving now
                if (cnt_q >= CAP_FIRST) begin
                    deinter_data_d[int'(cap_idx) * SYM_BITS +: SYM_BITS] = sym_in;
                end
                if (cnt_q == XFER_LAST) begin
                    deinter_en_d = 1'b1;
                    state_d      = DEINT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEINT: begin
                if (deinter_eno) begin
                    out_data_d   = dec_data;
                    deinter_en_d = 1'b0;
                    out_valid_d  = 1'b1;
                    state_d      = OUT;
                end else if (wdog_expire) begin
                    err_d        = 1'b1;
                    deinter_en_d = 1'b0;
                    src_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    out_valid_d = 1'b0;
                    src_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
`ifdef BER_CNT_EN
                    bit_err_cnt_d = ber_sum[32] ? 32'hFFFF_FFFF : ber_sum[31:0];
`endif
                end
            end
            default: begin
                src_ready_d  = 1'b0;
                inter_en_d   = 1'b0;
                deinter_en_d = 1'b0;
                out_valid_d  = 1'b0;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            frame_q        <= '0;
            deinter_data_q <= '0;
            src_word_q     <= '0;
            out_data_q     <= '0;
            frame_cnt_q    <= '0;
            src_ready_q    <= 1'b0;
            inter_en_q     <= 1'b0;
            deinter_en_q   <= 1'b0;
            out_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
`ifdef BER_CNT_EN
            bit_err_cnt_q  <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            frame_q        <= frame_d;
            deinter_data_q <= deinter_data_d;
            src_word_q     <= src_word_d;
            out_data_q     <= out_data_d;
            frame_cnt_q    <= frame_cnt_d;
            src_ready_q    <= src_ready_d;
            inter_en_q     <= inter_en_d;
            deinter_en_q   <= deinter_en_d;
            out_valid_q    <= out_valid_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
`ifdef BER_CNT_EN
            bit_err_cnt_q  <= bit_err_cnt_d;
`endif
        end
    end

    assign src_ready    = src_ready_q;
    assign src_word     = src_word_q;
    assign inter_en     = inter_en_q;
    assign deinter_en   = deinter_en_q;
    assign deinter_data = deinter_data_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign frame_cnt    = frame_cnt_q;
`ifdef BER_CNT_EN
    assign bit_err_cnt  = bit_err_cnt_q;
`endif

endmodule

// File: doc/link_frame_sequencer.md
Name: link_frame_sequencer

Overview:
Frame-level controller for the baseband loopback chain: Hamming encoders, interleaver, QPSK modulator, AWGN channel, QPSK demodulator, deinterleaver and Hamming decoders.
- Accepts one 16-bit source word per frame through a valid/ready handshake.
- Sequences the interleaver, serialises the interleaved frame into symbols, and reassembles received symbols after a fixed channel latency.
- Fires the deinterleaver, then presents the decoded word through a valid/ready handshake.
- Replaces the hand-coded counter sequencing in the top level.

Parameters:
FRAME_BITS, 28, interleaved frame width (4 x Hamming(7,4)).
SYM_BITS, 2, bits per QPSK symbol; NSYM = FRAME_BITS/SYM_BITS = 14 (derived).
CHAN_LAT, 3, cycles from a sym_out change to the edge where the matching sym_in is sampled (mod + channel + demod).
TIMEOUT, 64, maximum cycles to wait for inter_eno or deinter_eno.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
src_valid  in  1  source word offered.
src_ready  out  1  high only in IDLE.
src_data  in  16  source word.
src_word  out  16  latched source word, drives the Hamming encoders.
inter_en  out  1  interleaver enable.
inter_eno  in  1  interleaver result valid.
inter_data  in  FRAME_BITS  interleaved frame.
sym_out  out  SYM_BITS  symbol to the modulator.
sym_in  in  SYM_BITS  symbol from the demodulator.
deinter_en  out  1  deinterleaver enable.
deinter_data  out  FRAME_BITS  reassembled received frame.
deinter_eno  in  1  deinterleaver result valid.
dec_data  in  16  Hamming decoder output.
out_valid  out  1  decoded word available.
out_ready  in  1  consumer accepts.
out_data  out  16  decoded word.
busy  out  1  state != IDLE.
err  out  1  one-cycle pulse on timeout.
frame_cnt  out  16  completed frames, wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs and registers are 0 except src_ready, which is 1 once in IDLE.
- IDLE: src_valid & src_ready at an edge latches src_word <= src_data and moves to ENC.
- ENC: inter_en=1. Watchdog counts cycles.
  - Edge with inter_eno=1: latch frame <= inter_data, drop inter_en, clear cnt, go to XFER.
  - Watchdog reaches TIMEOUT: pulse err, go to IDLE, drop the frame.
- XFER: cnt increments every edge from 0 to NSYM-1+CHAN_LAT (16).
  - Combinational sym_out = frame[2*cnt+1:2*cnt] while cnt < NSYM, else 0.
  - At the edge where cnt == k+CHAN_LAT (k = 0..13): deinter_data[2k+1:2k] <= sym_in.
  - After the last capture edge, go to DEINT.
- DEINT: deinter_en=1.
  - Edge with deinter_eno=1: out_data <= dec_data, drop deinter_en, go to OUT.
  - Timeout: same handling as ENC.
- OUT: out_valid=1 with out_data stable.
  - Edge with out_ready=1: frame_cnt++, go to IDLE.
  - out_ready already high on entry: one-cycle OUT.
- Latency: accept at edge E0; eno returned in the first ENC cycle and the first DEINT cycle; out_valid is high after edge E19.
- src_valid outside IDLE is ignored. No queuing; the source must hold its word.
- An eno seen outside its wait state is ignored.
- Reset mid-frame aborts immediately. No err pulse.
- Back-to-back frames: OUT -> IDLE -> accept. Minimum frame period is 21 cycles.

Optional Feature:
Macro BER_CNT_EN.
- Defined: adds output port bit_err_cnt (32 bits, reset 0). At the OUT -> IDLE transition it adds popcount(src_word ^ out_data). Saturates at 32'hFFFFFFFF.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package link_seq_pkg:
  - state enum IDLE/ENC/XFER/DEINT/OUT.
  - SYM_BITS, FRAME_BITS, NSYM, CNT_W = $clog2(NSYM+CHAN_LAT+1).
  - Word width 16.
- One sub-module, link_wdog: loadable down-counter. Inputs clear/enable; output expire after TIMEOUT cycles. Instantiated once and shared by ENC and DEINT.

Test Plan:
- Reset, then src_data=16'h147C with src_valid -> src_ready=0 next cycle; src_word=16'h147C; inter_en=1.
- Bench returns inter_data=28'h5A3C96E at the first ENC cycle; sym_in = sym_out delayed 3 cycles -> sym_out sequence starts 2'b10, 2'b11, 2'b10; deinter_data=28'h5A3C96E at DEINT entry.
- deinter_eno at the first DEINT cycle with dec_data=16'h147C, out_ready=1 -> out_valid after edge E19; out_data=16'h147C; frame_cnt=1.
- inter_eno never asserted -> err pulses exactly once after 64 ENC cycles; state IDLE; src_ready=1; frame_cnt unchanged.
- Hold out_ready=0 for 10 cycles while src_valid=1 -> out_data stable and no new accept; release -> accept in the cycle after IDLE entry.
- Assert rst in XFER at cnt=7 -> all outputs 0 immediately; clean frame afterwards. With BER_CNT_EN, dec_data=16'h147D -> bit_err_cnt=1.
